// File: rtl/clock_pkg.sv
// Shared BCD limits and helpers for the time-of-day counter.
// Used by bcd_mod_counter and time_of_day_counter.
package clock_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    // Valid two-digit BCD: both nibbles are digits and the value does not exceed max.
    // With both nibbles <= 9 a plain binary compare orders BCD values correctly.
    function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
        return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MAX, with synchronous load.
// carry_o is combinational so a chain of these rolls over in a single cycle.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = SEC_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    output logic [7:0] value_o,
    output logic       carry_o
);

    logic [7:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = (value_q == MAX) ? BCD_ZERO : bcd_inc(value_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= BCD_ZERO;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign carry_o = inc_i && (value_q == MAX);

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter driven by a one-second tick, with validated load.
// Define ALARM_EN to add the hour:minute alarm registers and alarm_hit output.
module time_of_day_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_1s_i,
    input  logic       hold_i,
    input  logic       set_en_i,
    input  logic [7:0] set_hour_i,
    input  logic [7:0] set_min_i,
    input  logic [7:0] set_sec_i,
`ifdef ALARM_EN
    input  logic       alarm_set_i,
    input  logic [7:0] alarm_hour_i,
    input  logic [7:0] alarm_min_i,
    input  logic       alarm_on_i,
    output logic       alarm_hit_o,
`endif
    output logic [7:0] sec_bcd_o,
    output logic [7:0] min_bcd_o,
    output logic [7:0] hour_bcd_o,
    output logic       day_tick_o,
    output logic       set_err_o
);

    logic tick;
    logic set_ok;
    logic load;
    logic sec_carry, min_carry, hour_carry;
    logic set_err_d;
    logic day_tick_q, set_err_q;

    // A load in the same cycle, valid or not, swallows the tick.
    assign tick   = clk_1s_i && !hold_i && !set_en_i;
    assign set_ok = bcd_valid(set_sec_i, SEC_MAX) && bcd_valid(set_min_i, SEC_MAX) &&
                    bcd_valid(set_hour_i, HOUR_MAX);
    assign load   = set_en_i && set_ok;

    bcd_mod_counter #(
        .MAX(SEC_MAX)
    ) u_sec (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (tick),
        .load_i    (load),
        .load_val_i(set_sec_i),
        .value_o   (sec_bcd_o),
        .carry_o   (sec_carry)
    );

    bcd_mod_counter #(
        .MAX(SEC_MAX)
    ) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (sec_carry),
        .load_i    (load),
        .load_val_i(set_min_i),
        .value_o   (min_bcd_o),
        .carry_o   (min_carry)
    );

    bcd_mod_counter #(
        .MAX(HOUR_MAX)
    ) u_hour (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (min_carry),
        .load_i    (load),
        .load_val_i(set_hour_i),
        .value_o   (hour_bcd_o),
        .carry_o   (hour_carry)
    );

`ifdef ALARM_EN
    logic       alarm_ok;
    logic [7:0] alarm_hour_q, alarm_min_q;
    logic [7:0] min_next, hour_next;
    logic       alarm_hit_d, alarm_hit_q;

    assign alarm_ok = bcd_valid(alarm_hour_i, HOUR_MAX) && bcd_valid(alarm_min_i, SEC_MAX);

    // Only a tick that rolls seconds to 00 can land on hh:mm:00.
    always_comb begin
        min_next    = min_carry ? BCD_ZERO : bcd_inc(min_bcd_o);
        hour_next   = hour_carry ? BCD_ZERO : (min_carry ? bcd_inc(hour_bcd_o) : hour_bcd_o);
        alarm_hit_d = alarm_on_i && sec_carry &&
                      (min_next == alarm_min_q) && (hour_next == alarm_hour_q);
        set_err_d   = (set_en_i && !set_ok) || (alarm_set_i && !alarm_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour_q <= BCD_ZERO;
            alarm_min_q  <= BCD_ZERO;
            alarm_hit_q  <= 1'b0;
        end else begin
            if (alarm_set_i && alarm_ok) begin
                alarm_hour_q <= alarm_hour_i;
                alarm_min_q  <= alarm_min_i;
            end
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit_o = alarm_hit_q;
`else
    always_comb begin
        set_err_d = set_en_i && !set_ok;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            day_tick_q <= hour_carry;
            set_err_q  <= set_err_d;
        end
    end

    assign day_tick_o = day_tick_q;
    assign set_err_o  = set_err_q;

endmodule
